// File: rtl/lcd_dstn_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_dstn_if
//  Description : FIFO read side plus dual-scan colour STN panel bus for
//                lcd_dstn_timing. The master is the timing block; the slave
//                is the FIFO/panel side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_dstn_if;
    logic [5:0] lcd_rd_data;
    logic       lcd_rd_empty;
    logic       lcd_rd_en;
    logic [3:0] lcd_ud;
    logic [3:0] lcd_ld;
    logic       lcd_cp;
    logic       lcd_lp;
    logic       lcd_flm;
    logic       lcd_m;
    logic       vsync;
    logic       underflow;

    modport master (
        input  lcd_rd_data, lcd_rd_empty,
        output lcd_rd_en, lcd_ud, lcd_ld, lcd_cp, lcd_lp, lcd_flm, lcd_m,
               vsync, underflow
    );

    modport slave (
        output lcd_rd_data, lcd_rd_empty,
        input  lcd_rd_en, lcd_ud, lcd_ld, lcd_cp, lcd_lp, lcd_flm, lcd_m,
               vsync, underflow
    );
endinterface
`default_nettype wire

// File: rtl/lcd_dstn_timing.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_dstn_timing
//  Description : Drains the 6-bit LCD FIFO (one dithered pixel per panel
//                half), packs 3-bit subpixel groups into 4-bit nibbles per
//                half and drives CP/LP/FLM/M timing of a dual-scan colour
//                STN panel. vsync mirrors FLM back to the FRC stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_dstn_timing #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 240,
    parameter int CP_HALF  = 2,
    parameter int H_BLANK  = 16,
    parameter int LP_WIDTH = 4,
    parameter int M_LINES  = 0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    lcd_dstn_if.master lcd
);

    localparam int c_CPS = H_PIXELS * 3 / 4;
    localparam int c_HW  = $clog2(H_BLANK + 1);
    localparam int c_PW  = $clog2(CP_HALF + 1);
    localparam int c_NW  = $clog2(c_CPS + 1);
    localparam int c_LW  = $clog2(V_LINES + 1);
    localparam int c_MW  = $clog2(M_LINES + 2);

    localparam logic [1:0] c_ST_HBLANK = 2'd0;
    localparam logic [1:0] c_ST_CP_LO  = 2'd1;
    localparam logic [1:0] c_ST_CP_HI  = 2'd2;
    localparam logic [1:0] c_ST_STALL  = 2'd3;

    // Timing state
    logic [1:0]      r_state_q, w_state_d;
    logic [c_HW-1:0] r_hcnt_q,  w_hcnt_d;
    logic [c_PW-1:0] r_ph_q,    w_ph_d;
    logic [c_NW-1:0] r_ncp_q,   w_ncp_d;
    logic [c_LW-1:0] r_line_q,  w_line_d;
    logic [c_MW-1:0] r_mcnt_q,  w_mcnt_d;

    // Gearbox state: buffers are MSB-aligned, oldest bit in [7]
    logic [7:0]      r_ubuf_q,  w_ubuf_d;
    logic [7:0]      r_lbuf_q,  w_lbuf_d;
    logic [3:0]      r_cnt_q,   w_cnt_d;
    logic            r_inf_q;

    // Registered panel outputs
    logic [3:0]      r_ud_q,    w_ud_d;
    logic [3:0]      r_ld_q,    w_ld_d;
    logic            r_cp_q,    w_cp_d;
    logic            r_lp_q,    w_lp_d;
    logic            r_flm_q,   w_flm_d;
    logic            r_m_q,     w_m_d;
    logic            r_uf_q,    w_uf_d;

    logic [3:0]      w_avail;
    logic            w_rd_en;
    logic            w_due;
    logic            w_take;
    logic [7:0]      w_ub_app;
    logic [7:0]      w_lb_app;
    logic [3:0]      w_cnt_app;

    // Read request and line/CP sequencing; a CP falls due on HBLANK exit or
    // CP_HI exit, and is loaded only when 4 bits exist (counting data landing now)
    always_comb begin
        w_avail   = r_cnt_q + (r_inf_q ? 4'd3 : 4'd0);
        w_rd_en   = !rst && !lcd.lcd_rd_empty && (w_avail <= 4'd4);
        w_state_d = r_state_q;
        w_hcnt_d  = r_hcnt_q;
        w_ph_d    = r_ph_q;
        w_ncp_d   = r_ncp_q;
        w_line_d  = r_line_q;
        w_uf_d    = r_uf_q;
        w_due     = 1'b0;
        w_take    = 1'b0;
        case (r_state_q)
            c_ST_HBLANK: begin
                if (r_hcnt_q == c_HW'(H_BLANK - 1)) begin
                    w_hcnt_d = '0;
                    w_due    = 1'b1;
                end else begin
                    w_hcnt_d = r_hcnt_q + 1'b1;
                end
            end
            c_ST_CP_LO: begin
                if (r_ph_q == c_PW'(CP_HALF - 1)) begin
                    w_ph_d    = '0;
                    w_state_d = c_ST_CP_HI;
                end else begin
                    w_ph_d = r_ph_q + 1'b1;
                end
            end
            c_ST_CP_HI: begin
                if (r_ph_q == c_PW'(CP_HALF - 1)) begin
                    w_ph_d = '0;
                    if (r_ncp_q == c_NW'(c_CPS - 1)) begin
                        w_ncp_d   = '0;
                        w_hcnt_d  = '0;
                        w_state_d = c_ST_HBLANK;
                        w_line_d  = (r_line_q == c_LW'(V_LINES - 1)) ? '0 : r_line_q + 1'b1;
                    end else begin
                        w_ncp_d = r_ncp_q + 1'b1;
                        w_due   = 1'b1;
                    end
                end else begin
                    w_ph_d = r_ph_q + 1'b1;
                end
            end
            default: begin
                w_due = 1'b1;
            end
        endcase
        if (w_due) begin
            if (w_avail >= 4'd4) begin
                w_take    = 1'b1;
                w_ph_d    = '0;
                w_state_d = c_ST_CP_LO;
            end else begin
                w_uf_d    = 1'b1;
                w_state_d = c_ST_STALL;
            end
        end
    end

    // Gearbox: append the returning entry first, then consume 4 bits, so a
    // same-clock return and CP load net out to count + 3 - 4
    always_comb begin
        w_ub_app  = r_ubuf_q;
        w_lb_app  = r_lbuf_q;
        w_cnt_app = r_cnt_q;
        if (r_inf_q) begin
            w_ub_app  = r_ubuf_q | ({lcd.lcd_rd_data[5:3], 5'b0} >> r_cnt_q);
            w_lb_app  = r_lbuf_q | ({lcd.lcd_rd_data[2:0], 5'b0} >> r_cnt_q);
            w_cnt_app = r_cnt_q + 4'd3;
        end
        w_ubuf_d = w_ub_app;
        w_lbuf_d = w_lb_app;
        w_cnt_d  = w_cnt_app;
        w_ud_d   = r_ud_q;
        w_ld_d   = r_ld_q;
        if (w_take) begin
            w_ud_d   = w_ub_app[7:4];
            w_ld_d   = w_lb_app[7:4];
            w_ubuf_d = w_ub_app << 4;
            w_lbuf_d = w_lb_app << 4;
            w_cnt_d  = w_cnt_app - 4'd4;
        end
    end

    // Panel strobes decoded from the next state; M flips on LP rising edges
    always_comb begin
        w_cp_d   = (w_state_d == c_ST_CP_HI);
        w_lp_d   = (w_state_d == c_ST_HBLANK) && (w_hcnt_d >= c_HW'(1)) &&
                   (w_hcnt_d <= c_HW'(LP_WIDTH));
        w_flm_d  = w_lp_d && (w_line_d == c_LW'(V_LINES - 1));
        w_m_d    = r_m_q;
        w_mcnt_d = r_mcnt_q;
        if (w_lp_d && !r_lp_q) begin
            if (M_LINES == 0) begin
                if (w_flm_d) begin
                    w_m_d = !r_m_q;
                end
            end else if (r_mcnt_q == c_MW'(M_LINES - 1)) begin
                w_mcnt_d = '0;
                w_m_d    = !r_m_q;
            end else begin
                w_mcnt_d = r_mcnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards the partial line and any in-flight read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_HBLANK;
            r_hcnt_q  <= '0;
            r_ph_q    <= '0;
            r_ncp_q   <= '0;
            r_line_q  <= c_LW'(V_LINES - 1);
            r_mcnt_q  <= '0;
            r_ubuf_q  <= '0;
            r_lbuf_q  <= '0;
            r_cnt_q   <= '0;
            r_inf_q   <= 1'b0;
            r_ud_q    <= '0;
            r_ld_q    <= '0;
            r_cp_q    <= 1'b0;
            r_lp_q    <= 1'b0;
            r_flm_q   <= 1'b0;
            r_m_q     <= 1'b0;
            r_uf_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_hcnt_q  <= w_hcnt_d;
            r_ph_q    <= w_ph_d;
            r_ncp_q   <= w_ncp_d;
            r_line_q  <= w_line_d;
            r_mcnt_q  <= w_mcnt_d;
            r_ubuf_q  <= w_ubuf_d;
            r_lbuf_q  <= w_lbuf_d;
            r_cnt_q   <= w_cnt_d;
            r_inf_q   <= w_rd_en;
            r_ud_q    <= w_ud_d;
            r_ld_q    <= w_ld_d;
            r_cp_q    <= w_cp_d;
            r_lp_q    <= w_lp_d;
            r_flm_q   <= w_flm_d;
            r_m_q     <= w_m_d;
            r_uf_q    <= w_uf_d;
        end
    end

    assign lcd.lcd_rd_en = w_rd_en;
    assign lcd.lcd_ud    = r_ud_q;
    assign lcd.lcd_ld    = r_ld_q;
    assign lcd.lcd_cp    = r_cp_q;
    assign lcd.lcd_lp    = r_lp_q;
    assign lcd.lcd_flm   = r_flm_q;
    assign lcd.lcd_m     = r_m_q;
    assign lcd.vsync     = r_flm_q;
    assign lcd.underflow = r_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_dstn_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_dstn_timing
//  Description : Directed self-checking bench for lcd_dstn_timing with a
//                small FIFO model (main DUT, M_LINES=0) and an always-full
//                source (second DUT, M_LINES=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_dstn_timing;
    localparam int H_PIXELS = 8;
    localparam int V_LINES  = 4;
    localparam int CP_HALF  = 1;
    localparam int H_BLANK  = 4;
    localparam int LP_WIDTH = 2;
    localparam int CPS      = H_PIXELS * 3 / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_dstn_if bus ();
    lcd_dstn_if bus3 ();

    lcd_dstn_timing #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .CP_HALF(CP_HALF),
                      .H_BLANK(H_BLANK), .LP_WIDTH(LP_WIDTH), .M_LINES(0))
        u_dut (.clk(clk), .rst(rst), .lcd(bus));

    lcd_dstn_timing #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .CP_HALF(CP_HALF),
                      .H_BLANK(H_BLANK), .LP_WIDTH(LP_WIDTH), .M_LINES(3))
        u_dut3 (.clk(clk), .rst(rst), .lcd(bus3));

    // FIFO model (standard read: data valid the clk after rd_en is sampled)
    logic [5:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    bit         force_empty = 1'b0;
    logic [5:0] rd_data_q = '0;
    assign bus.lcd_rd_empty  = force_empty || (rd_ptr == wr_ptr);
    assign bus.lcd_rd_data   = rd_data_q;
    assign bus3.lcd_rd_empty = 1'b0;
    assign bus3.lcd_rd_data  = 6'b101100;
    always @(posedge clk) begin
        if (bus.lcd_rd_en && !bus.lcd_rd_empty) begin
            rd_data_q <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic [3:0] cap_ud [0:255];
    logic [3:0] cap_ld [0:255];
    int cap_n, cp_in_line, lp_n, flm_n, bad_line, bad_flm, bad_vsync, m_tog, bad_m;
    int lp3_n, m3_tog, bad_m3;
    logic p_cp, p_lp, p_m, p3_lp, p3_m;
    logic [2:0] exp_seq [0:4];

    task automatic clear_mon();
        cap_n = 0; cp_in_line = 0; lp_n = 0; flm_n = 0; bad_line = 0; bad_flm = 0;
        bad_vsync = 0; m_tog = 0; bad_m = 0; lp3_n = 0; m3_tog = 0; bad_m3 = 0;
        p_cp = 1'b0; p_lp = 1'b0; p_m = 1'b0; p3_lp = 1'b0; p3_m = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample everything on the falling edge
    task automatic tick();
        bit lp_rise, lp3_rise;
        @(negedge clk);
        lp_rise  = bus.lcd_lp && !p_lp;
        lp3_rise = bus3.lcd_lp && !p3_lp;
        if (bus.lcd_cp && !p_cp) begin
            if (cap_n < 256) begin
                cap_ud[cap_n] = bus.lcd_ud;
                cap_ld[cap_n] = bus.lcd_ld;
            end
            cap_n++;
            cp_in_line++;
        end
        if (lp_rise) begin
            lp_n++;
            if (lp_n > 1 && cp_in_line != CPS) bad_line++;
            cp_in_line = 0;
            if (bus.lcd_flm) begin
                flm_n++;
                if ((lp_n - 1) % V_LINES != 0) bad_flm++;
            end
        end
        if (bus.lcd_flm && !bus.lcd_lp) bad_flm++;
        if (bus.vsync !== bus.lcd_flm) bad_vsync++;
        if (bus.lcd_m !== p_m) begin
            m_tog++;
            if (!(lp_rise && bus.lcd_flm)) bad_m++;
        end
        if (lp3_rise) lp3_n++;
        if (bus3.lcd_m !== p3_m) begin
            m3_tog++;
            if (!lp3_rise || (lp3_n % 3 != 0)) bad_m3++;
        end
        p_cp = bus.lcd_cp; p_lp = bus.lcd_lp; p_m = bus.lcd_m;
        p3_lp = bus3.lcd_lp; p3_m = bus3.lcd_m;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_zero"}, {17'd0, bus.lcd_ud, bus.lcd_ld, bus.lcd_cp, bus.lcd_lp,
              bus.lcd_flm, bus.lcd_m, bus.vsync, bus.underflow, bus.lcd_rd_en}, 32'd0);
        check({tag, "_zero3"}, {17'd0, bus3.lcd_ud, bus3.lcd_ld, bus3.lcd_cp, bus3.lcd_lp,
              bus3.lcd_flm, bus3.lcd_m, bus3.vsync, bus3.underflow, bus3.lcd_rd_en}, 32'd0);
    endtask

    task automatic restart_seq(input string tag);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("%s_lp_flm_cp%0d", tag, i),
                  {29'd0, bus.lcd_lp, bus.lcd_flm, bus.lcd_cp}, {29'd0, exp_seq[i]});
        end
    endtask

    // Expected nibble i of a half's bit stream, R first, MSB = earliest
    function automatic logic [3:0] exp_nib(input int i, input bit upper);
        logic [3:0] n;
        logic [5:0] e;
        int         j;
        n = '0;
        for (int b = 0; b < 4; b++) begin
            j = 4 * i + b;
            e = mem[j / 3];
            n[3 - b] = upper ? e[5 - (j % 3)] : e[2 - (j % 3)];
        end
        return n;
    endfunction

    initial begin
        int n;
        logic [3:0] ud_hold, ld_hold;
        bit cp_seen;
        exp_seq[0] = 3'b110; exp_seq[1] = 3'b110; exp_seq[2] = 3'b000;
        exp_seq[3] = 3'b000; exp_seq[4] = 3'b001;
        mem[0] = 6'b100011; mem[1] = 6'b010101; mem[2] = 6'b111000; mem[3] = 6'b001110;
        for (int k = 4; k < 256; k++) mem[k] = 6'((k * 29 + 7) % 64);
        wr_ptr = 256;
        clear_mon();

        // Scenario 1: reset for 3 clocks, then LP/FLM window and first CP
        rst = 1'b1;
        repeat (3) tick();
        check_zero("rst1");
        rst = 1'b0;
        restart_seq("start1");

        // Scenario 2: first three CPs carry the hand-packed nibbles
        n = 0;
        while (cap_n < 3 && n < 100) begin tick(); n++; end
        check("wait_cp3", {31'd0, cap_n >= 3}, 32'd1);
        check("ud_cp1", {28'd0, cap_ud[0]}, 32'b1000);
        check("ud_cp2", {28'd0, cap_ud[1]}, 32'b1011);
        check("ud_cp3", {28'd0, cap_ud[2]}, 32'b1001);
        check("ld_cp1", {28'd0, cap_ld[0]}, 32'b0111);
        check("ld_cp2", {28'd0, cap_ld[1]}, 32'b0100);
        check("ld_cp3", {28'd0, cap_ld[2]}, 32'b0110);
        check("no_underflow", {31'd0, bus.underflow}, 32'd0);

        // Scenario 3: FIFO starved for 10 clocks in the middle of line 1
        n = 0;
        while (cap_n < 8 && n < 100) begin tick(); n++; end
        check("wait_cp8", {31'd0, cap_n >= 8}, 32'd1);
        force_empty = 1'b1;
        cp_seen = 1'b0;
        ud_hold = '0;
        ld_hold = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 7) begin ud_hold = bus.lcd_ud; ld_hold = bus.lcd_ld; end
            if (i >= 7 && bus.lcd_cp) cp_seen = 1'b1;
        end
        check("stall_cp_low", {31'd0, cp_seen}, 32'd0);
        check("stall_ud_hold", {28'd0, bus.lcd_ud}, {28'd0, ud_hold});
        check("stall_ld_hold", {28'd0, bus.lcd_ld}, {28'd0, ld_hold});
        check("underflow_set", {31'd0, bus.underflow}, 32'd1);
        force_empty = 1'b0;

        // Scenarios 4/5: two full frames of timing
        n = 0;
        while (lp_n < 9 && n < 600) begin tick(); n++; end
        check("wait_2frames", {31'd0, lp_n >= 9}, 32'd1);
        check("cps_total", cap_n, 32'd48);
        check("cps_per_line_bad", bad_line, 32'd0);
        check("flm_count", flm_n, 32'd3);
        check("flm_place_bad", bad_flm, 32'd0);
        check("vsync_bad", bad_vsync, 32'd0);
        check("m0_toggles", m_tog, 32'd3);
        check("m0_place_bad", bad_m, 32'd0);
        check("m3_toggles", m3_tog, lp3_n / 3);
        check("m3_place_bad", bad_m3, 32'd0);
        check("underflow_sticky", {31'd0, bus.underflow}, 32'd1);
        for (int i = 0; i < 48; i++) begin
            check($sformatf("ud_stream%0d", i), {28'd0, cap_ud[i]}, {28'd0, exp_nib(i, 1'b1)});
            check($sformatf("ld_stream%0d", i), {28'd0, cap_ld[i]}, {28'd0, exp_nib(i, 1'b0)});
        end

        // Scenario 6: reset at CP 3 of line 2 of the third frame
        n = 0;
        while (!(lp_n == 11 && cp_in_line == 3) && n < 400) begin tick(); n++; end
        check("wait_line2_cp3", {31'd0, lp_n == 11 && cp_in_line == 3}, 32'd1);
        rst = 1'b1;
        tick();
        check_zero("rst2");
        tick();
        tick();
        clear_mon();
        rst = 1'b0;
        restart_seq("start2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
